// File: rtl/ahb_pkg.sv
// Shared AHB encodings, size constants and the SRAM slave state type.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'd0,
        HRESP_ERROR = 2'd1,
        HRESP_RETRY = 2'd2,
        HRESP_SPLIT = 2'd3
    } hresp_t;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_XFER,
        ST_ERR1,
        ST_ERR2
    } sram_state_t;

    // Little-endian byte-lane enables for an aligned transfer.
    function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] addr);
        case (size)
            2'd0:    return 4'b0001 << addr;
            2'd1:    return addr[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB bus signals seen by the SRAM slave; HREADYIN comes from the fabric.
interface ahb_sram_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic        HREADYIN;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic [1:0]  HRESP;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HPROT, HWDATA, HREADYIN,
        output HREADYOUT, HRDATA, HRESP
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HPROT, HWDATA, HREADYIN,
        input  HREADYOUT, HRDATA, HRESP
    );
endinterface

// File: rtl/ahb_sram_array.sv
// Byte-lane SRAM: one narrow array per lane, synchronous write, asynchronous read.
module ahb_sram_array #(
    parameter  int MEM_WORDS = 1024,
    localparam int AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_mem [MEM_WORDS];

        always_ff @(posedge clk_i) begin
            if (we_i && be_i[gi]) begin
                lane_mem[waddr_i] <= wdata_i[8*gi +: 8];
            end
        end

        assign rdata_o[8*gi +: 8] = lane_mem[raddr_i];
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB SRAM slave with configurable wait states and two-cycle ERROR response.
// Define AHB_SRAM_WRITE_PROTECT_EN to reject user-mode writes to the upper half.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 0
) (
    input logic             HCLK,
    input logic             HRESETn,
    ahb_sram_slave_if.slave bus
);

    localparam int          AW         = $clog2(MEM_WORDS);
    localparam int          BW         = AW + 2;
    localparam logic [32:0] ADDR_LIMIT = 33'(4 * MEM_WORDS);
    localparam logic [3:0]  WS_INIT    = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    sram_state_t   state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [BW-1:0] addr_q, addr_d;
    logic [1:0]    size_q, size_d;
    logic          write_q, write_d;
    logic [31:0]   hrdata_q, hrdata_d;
    logic          hready_q;
    hresp_t        hresp_q;

    logic          accept, bad, prot_bad;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] raddr;
    logic [31:0]   mem_rdata, fwd_rdata;
    logic          unused_hprot;

    assign accept = bus.HSEL && bus.HREADYIN &&
                    (bus.HTRANS == HTRANS_NONSEQ || bus.HTRANS == HTRANS_SEQ);

`ifdef AHB_SRAM_WRITE_PROTECT_EN
    assign prot_bad = bus.HWRITE && ({1'b0, bus.HADDR} >= 33'(2 * MEM_WORDS)) && !bus.HPROT[1];
`else
    assign prot_bad = 1'b0;
`endif
    assign unused_hprot = ^bus.HPROT;

    assign bad = (bus.HSIZE > HSIZE_WORD) ||
                 (bus.HSIZE == HSIZE_HALF && bus.HADDR[0]) ||
                 (bus.HSIZE == HSIZE_WORD && bus.HADDR[1:0] != 2'b00) ||
                 ({1'b0, bus.HADDR} >= ADDR_LIMIT) ||
                 prot_bad;

    // Writes land on the edge that ends XFER, so a read launched on that edge sees them via forwarding.
    assign mem_we = (state_q == ST_XFER) && write_q;
    assign mem_be = lane_enables(size_q, addr_q[1:0]);
    assign raddr  = (state_q == ST_WAIT) ? addr_q[BW-1:2] : bus.HADDR[BW-1:2];

    for (genvar gi = 0; gi < 4; gi++) begin : g_fwd
        assign fwd_rdata[8*gi +: 8] = (mem_we && mem_be[gi] && raddr == addr_q[BW-1:2])
                                      ? bus.HWDATA[8*gi +: 8] : mem_rdata[8*gi +: 8];
    end

    ahb_sram_array #(.MEM_WORDS(MEM_WORDS)) u_array (
        .clk_i   (HCLK),
        .we_i    (mem_we),
        .be_i    (mem_be),
        .waddr_i (addr_q[BW-1:2]),
        .wdata_i (bus.HWDATA),
        .raddr_i (raddr),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        size_d   = size_q;
        write_d  = write_q;
        hrdata_d = hrdata_q;
        case (state_q)
            ST_WAIT: begin
                if (cnt_q == 4'd0) state_d = ST_XFER;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                // IDLE, XFER and ERR2 all accept a new address phase.
                state_d = ST_IDLE;
                if (accept) begin
                    addr_d  = bus.HADDR[BW-1:0];
                    size_d  = bus.HSIZE[1:0];
                    write_d = bus.HWRITE;
                    if (bad) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WS_INIT;
                    end else begin
                        state_d = ST_XFER;
                    end
                end
            end
        endcase
        if (state_d == ST_XFER && !write_d) hrdata_d = fwd_rdata;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= '0;
            size_q   <= 2'd0;
            write_q  <= 1'b0;
            hrdata_q <= 32'd0;
            hready_q <= 1'b1;
            hresp_q  <= HRESP_OKAY;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            write_q  <= write_d;
            hrdata_q <= hrdata_d;
            hready_q <= !(state_d == ST_WAIT || state_d == ST_ERR1);
            hresp_q  <= (state_d == ST_ERR1 || state_d == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
        end
    end

    assign bus.HREADYOUT = hready_q;
    assign bus.HRESP     = hresp_q;
    assign bus.HRDATA    = hrdata_q;

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB slave responder for the on-chip SRAM region, driven by HSEL1 from the bus decoder.
- Accepts pipelined address/data-phase transfers from the arbitrated master (CPU core or UART).
- Supports byte, halfword and word reads/writes with a configurable number of wait states.
- Returns the standard two-cycle ERROR response for illegal transfers.

Parameters:
- MEM_WORDS, 1024, SRAM depth in 32-bit words. Byte address range is 0 .. 4*MEM_WORDS-1.
- WAIT_STATES, 0, extra HREADYOUT-low cycles inserted in every OKAY data phase (0..15).

Ports:
- HCLK input 1 bus clock
- HRESETn input 1 async active-low reset
- HSEL input 1 slave select from decoder
- HADDR input 32 byte address
- HTRANS input 2 0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
- HWRITE input 1 1 = write
- HSIZE input 3 0 byte, 1 halfword, 2 word
- HPROT input 4 protection; bit1 = privileged
- HWDATA input 32 write data (data phase)
- HREADYIN input 1 bus-wide ready; previous transfer complete
- HREADYOUT output 1 this slave's ready
- HRDATA output 32 read data
- HRESP output 2 0 OKAY, 1 ERROR

Behaviour:
- Reset is HRESETn, asynchronous, active-low; clock is HCLK. Outputs at reset: HREADYOUT=1, HRESP=0, HRDATA=0, state IDLE. SRAM contents are not reset.
- Reset mid-transfer aborts the transfer. A write in progress is not committed.
- Address phase is accepted when HSEL & HREADYIN & HTRANS[1]. On acceptance, register addr, size, write and prot for the data phase.
- IDLE and BUSY transfers, or HSEL=0, are not accepted. The next cycle gives zero-wait OKAY.
- Error conditions:
  - HSIZE>2.
  - Misalignment: HSIZE=1 with HADDR[0]=1, or HSIZE=2 with HADDR[1:0]!=0.
  - HADDR >= 4*MEM_WORDS.
- On an error, the array is untouched.
- States:
  - IDLE: no data phase pending.
  - WAIT: counting WAIT_STATES with HREADYOUT=0, HRESP=OKAY.
  - XFER: HREADYOUT=1, HRESP=OKAY. The transfer completes here.
  - ERR1: HREADYOUT=0, HRESP=ERROR.
  - ERR2: HREADYOUT=1, HRESP=ERROR.
- Transitions:
  - A good accept goes to WAIT if WAIT_STATES>0, else to XFER.
  - WAIT goes to XFER after WAIT_STATES cycles.
  - A bad accept goes to ERR1, then ERR2.
  - From XFER or ERR2: if a new transfer is accepted in the same cycle, evaluate it as above (back-to-back pipelining). Otherwise go to IDLE.
- Write: HWDATA is sampled and committed in the XFER cycle (the cycle where HREADYOUT=1). Byte lanes are little-endian:
  - byte: lane HADDR[1:0]
  - halfword: lanes {HADDR[1],0}+{0,1}
  - word: all lanes
  - Unselected lanes are unchanged.
- Read: HRDATA holds the full addressed word during XFER. Latency is 1+WAIT_STATES cycles after the address phase. HRDATA holds its last value otherwise.
- Write then read of the same address back-to-back returns the new data. The write commits at the end of its data phase, before the read's data phase.
- HREADYOUT from ERR1/WAIT is only low while this slave owns the data phase.

Optional Feature:
- AHB_SRAM_WRITE_PROTECT_EN defined: a write to the upper half of SRAM (addr >= 2*MEM_WORDS) with HPROT[1]=0 (user) gets the two-cycle ERROR response. Nothing is written. Reads are unaffected.
- AHB_SRAM_WRITE_PROTECT_EN undefined: HPROT is ignored.

Decomposition:
- ahb_pkg holds:
  - htrans_t enum (IDLE/BUSY/NONSEQ/SEQ)
  - hresp_t enum (OKAY/ERROR/RETRY/SPLIT)
  - HSIZE_BYTE/HALF/WORD constants
  - slave FSM state enum
- Sub-module ahb_sram_array: MEM_WORDS x 32 storage, 4-bit byte-enable write port, asynchronous read port.

Test Plan:
- WAIT_STATES=0: word write 0xDEADBEEF to 0x10, then read 0x10. The read data phase, one cycle after its address phase, returns 0xDEADBEEF with HRESP=0.
- Byte write 0xAB to 0x13 over word 0x11223344. A read of 0x10 returns 0xAB223344. A halfword write 0x5566 to 0x12 then gives 0x55663344.
- Word read at 0x02: ERR1 cycle (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1). Memory is unchanged.
- WAIT_STATES=2: back-to-back NONSEQ reads of 0x0 and 0x4. Each data phase shows 2 HREADYOUT-low cycles, then data. Order is preserved.
- HTRANS=BUSY or HSEL=0 with HWRITE=1: HREADYOUT=1, HRESP=0 next cycle, and no array change.
- With AHB_SRAM_WRITE_PROTECT_EN defined:
  - User write (HPROT=0) to 4*MEM_WORDS-4 gets ERROR and the word is unchanged.
  - Privileged write (HPROT=2) to the same address succeeds.
